// File: rtl/pipelined_carry_adder_if.sv
// pipelined_carry_adder_if
// Groups the operand-side and result-side valid/ready handshakes of the
// pipelined carry adder into one bundle.
//
// Parameter:
//   WIDTH      operand and result width
//
// Signals:
//   in_valid   producer has operands A/B/Cin (and sub) on the bus
//   in_ready   adder can take operands this cycle
//   A, B       operands
//   Cin        carry-in
//   sub        subtract select, only present when PIPE_ADD_SUB_EN is defined
//   out_valid  Sum/Cout/Ovf hold a result
//   out_ready  consumer takes the result this cycle
//   Sum        result
//   Cout       carry out of the MSB
//   Ovf        two's-complement overflow
//
// Modports:
//   master     the side that supplies operands and consumes results
//   slave      the adder itself
//
// Optional feature macro: PIPE_ADD_SUB_EN adds the sub signal.

interface pipelined_carry_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;
`ifdef PIPE_ADD_SUB_EN
   logic             sub;

   modport master (
      output in_valid, A, B, Cin, sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, sub, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
`else
   modport master (
      output in_valid, A, B, Cin, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
`endif
endinterface

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder
// A WIDTH-bit adder that is cut into STAGES equal slices. Each slice is a
// ripple chain of full_adder cells. Between slices the partial sum, the
// operand bits still to be added and the slice carry are registered. Both
// sides use a valid/ready handshake, and stalls propagate back through a
// ready chain.
//
// Parameters:
//   WIDTH    operand/result width, must be a multiple of STAGES
//   STAGES   pipeline depth and slice count, 1..WIDTH
//
// Ports:
//   clk      clock, all state changes on its rising edge
//   rst_n    synchronous active-low reset
//   bus      pipelined_carry_adder_if.slave (operands in, result out)
//
// Optional feature macro: PIPE_ADD_SUB_EN
//   When defined, bus.sub = 1 computes A - B - Cin as A + ~B + ~Cin.
//   When undefined, the block only adds.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module pipelined_carry_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipelined_carry_adder_if.slave bus
);
   localparam int SLICE = WIDTH / STAGES;

   // Bit offset of stage k's leftover-B register inside bPipe. Stage k keeps
   // (STAGES-1-k) slices of B, so the offsets are a running triangular sum.
   function automatic int bOffset(input int k);
      return SLICE * (k * (STAGES - 1) - (k * (k - 1)) / 2);
   endfunction

   localparam int BTOT = (STAGES > 1) ? bOffset(STAGES - 1) : 1;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : gBadConfig
      $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
   end

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  accArr [STAGES];
   logic [STAGES-1:0] carryArr;
   logic [BTOT-1:0]   bPipe;
   logic [WIDTH-1:0]  bEff;
   logic              cinEff;
   logic              msbCarryIn;

   // Subtraction is folded into the operands at capture time. The inverted
   // B and carry-in then travel down the pipe with the rest of the
   // operation, so no later stage needs to know about sub.
`ifdef PIPE_ADD_SUB_EN
   assign bEff   = bus.sub ? ~bus.B   : bus.B;
   assign cinEff = bus.sub ? ~bus.Cin : bus.Cin;
`else
   assign bEff   = bus.B;
   assign cinEff = bus.Cin;
`endif

   // Ready chain: a stage may load when it is empty or when the stage after
   // it is also moving. The chain starts at the consumer's out_ready, so an
   // empty slot anywhere lets everything upstream of it advance.
   always_comb begin
      adv = '0;
      adv[STAGES-1] = !vld[STAGES-1] || bus.out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = !vld[k] || adv[k+1];
      end
   end

   if (STAGES == 1) begin : gNoB
      assign bPipe = '0;
   end

   for (genvar k = 0; k < STAGES; k++) begin : gStage
      localparam int LO   = k * SLICE;
      localparam int REMW = WIDTH - LO;

      // srcAcc holds finished sum slices below LO and untouched A above it.
      // srcB holds only the B slices from slice k upwards.
      logic [WIDTH-1:0] srcAcc;
      logic [REMW-1:0]  srcB;
      logic             srcCarry;
      logic             srcValid;
      logic [SLICE:0]   chain;
      logic [SLICE-1:0] sliceSum;
      logic [WIDTH-1:0] accD;
      logic [WIDTH-1:0] accQ;
      logic             vldQ;
      logic             carryQ;

      if (k == 0) begin : gFromInput
         assign srcAcc   = bus.A;
         assign srcB     = bEff;
         assign srcCarry = cinEff;
         assign srcValid = bus.in_valid;
      end else begin : gFromPrev
         assign srcAcc   = accArr[k-1];
         assign srcB     = bPipe[bOffset(k-1) +: REMW];
         assign srcCarry = carryArr[k-1];
         assign srcValid = vld[k-1];
      end

      assign chain[0] = srcCarry;

      for (genvar i = 0; i < SLICE; i++) begin : gBit
         full_adder uFa (
            .a  (srcAcc[LO+i]),
            .b  (srcB[i]),
            .ci (chain[i]),
            .s  (sliceSum[i]),
            .co (chain[i+1])
         );
      end

      // The slice result overwrites the A bits it consumed; the other bits
      // pass through unchanged.
      always_comb begin
         accD = srcAcc;
         accD[LO +: SLICE] = sliceSum;
      end

      // Stage register. Loading valid from the predecessor on every advance
      // is what lets bubbles collapse as work moves forward.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vldQ   <= 1'b0;
            accQ   <= '0;
            carryQ <= 1'b0;
         end else if (adv[k]) begin
            vldQ   <= srcValid;
            accQ   <= accD;
            carryQ <= chain[SLICE];
         end
      end

      assign vld[k]      = vldQ;
      assign accArr[k]   = accQ;
      assign carryArr[k] = carryQ;

      if (k < STAGES - 1) begin : gKeepB
         localparam int BW = WIDTH - (k + 1) * SLICE;
         logic [BW-1:0] bRemQ;

         // B slices not yet consumed; the low slice has just been used.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               bRemQ <= '0;
            end else if (adv[k]) begin
               bRemQ <= srcB[REMW-1:SLICE];
            end
         end

         assign bPipe[bOffset(k) +: BW] = bRemQ;
      end else begin : gMsb
         logic msbQ;

         // Carry into the MSB is kept so overflow can be formed from
         // registered values only.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               msbQ <= 1'b0;
            end else if (adv[k]) begin
               msbQ <= chain[SLICE-1];
            end
         end

         assign msbCarryIn = msbQ;
      end
   end

   assign bus.in_ready  = rst_n & adv[0];
   assign bus.out_valid = vld[STAGES-1];
   assign bus.Sum       = accArr[STAGES-1];
   assign bus.Cout      = carryArr[STAGES-1];
   assign bus.Ovf       = msbCarryIn ^ carryArr[STAGES-1];

endmodule

// File: doc/pipelined_carry_adder.md
# pipelined_carry_adder

Parametrised, pipelined successor to the team's 4-bit structural ripple-carry adder. Splits a WIDTH-bit add into STAGES equal slices, each a generate-built full-adder chain, with carry and operands registered between slices. A valid/ready handshake on both sides supports back-pressure, and a signed-overflow flag is produced. Used wherever wide adds must close timing at full clock rate in datapath blocks.

## Interface
- WIDTH, 16, operand/result width; must be an exact multiple of STAGES, otherwise elaboration fails.
- STAGES, 4, pipeline depth and slice count; range 1..WIDTH; slice width is WIDTH/STAGES.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  pipeline can accept operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- Sum  out  WIDTH  result.
- Cout  out  1  carry out of the MSB.
- Ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- sub  in  1  subtract select; present only with PIPE_ADD_SUB_EN.

## Operation
- Stage k (0..STAGES-1) adds slice k of the carried A/B using a ripple chain of full_adder instances.
  - The carry-in to stage k is the carry registered by stage k-1; stage 0 uses Cin.
- Each stage register holds:
  - a valid bit v[k]
  - sum slices 0..k
  - untouched operand slices k+1..STAGES-1
  - the slice carry-out
  - the MSB carry-in (last stage only, for Ovf)
- Advance rule: adv[S-1] = !v[S-1] | out_ready; adv[k] = !v[k] | adv[k+1].
  - Stage k loads from its predecessor (or from the input for k=0) when adv[k] is 1.
  - It loads valid = predecessor valid (in_valid for k=0). Bubbles therefore collapse.
- in_ready = adv[0], combinational from out_ready through the chain.
- Transfer occurs when in_valid & in_ready; the output transfer occurs when out_valid & out_ready.
- out_valid = v[S-1]. Sum/Cout/Ovf come straight from the last stage register.
- Results emerge in acceptance order; none are dropped or duplicated.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). No other width extension.
- Reset: while rst_n is low at a rising edge:
  - all v[k] become 0, and all data registers, Sum, Cout and Ovf become 0.
  - in_ready is driven 0 combinationally while rst_n is low.
  - In-flight operations are discarded and never appear at the output.
- After reset release, the pipeline is empty and in_ready = 1 (assuming no out_ready dependency, since all stages are empty).

## Timing
- Latency: operands accepted at edge t produce out_valid = 1 after edge t+STAGES-1, with no stall. With STAGES=1, the result is valid the cycle after acceptance.
- Throughput: one result per clock while out_ready = 1.
- Stall: while out_valid & !out_ready, Sum/Cout/Ovf stay stable and the last stage holds.
  - Upstream stages continue to fill their empty slots.
  - in_ready drops only when every stage is valid and blocked.
- Simultaneous accept with a full pipeline and out_ready = 1: legal. Every stage shifts and the new operand enters stage 0 in the same edge.
- Critical path: one slice ripple (WIDTH/STAGES full adders) plus the register; the ready chain is STAGES gates deep.

## Configuration
- PIPE_ADD_SUB_EN defined:
  - Port sub exists and is captured with the operands, travelling with them.
  - sub = 1 computes A - B - Cin, implemented as A + ~B + ~Cin.
    - Cout = 1 means no borrow.
    - Ovf is signed subtract overflow.
  - sub = 0 is identical to add.
- PIPE_ADD_SUB_EN undefined: no sub port and no inversion logic; the block is add-only.

## Test plan
- WIDTH=16, STAGES=4. Accept A=0x0005, B=0x0003, Cin=0 -> after 4 edges, out_valid=1, Sum=0x0008, Cout=0, Ovf=0.
- A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0; the carry crosses all three stage boundaries. Also A=0x7FFF, B=0x0001 -> Sum=0x8000, Ovf=1.
- Stream 8 back-to-back random operands with out_ready=1 -> 8 results on consecutive cycles, in order, each matching the model.
- Fill the pipeline, then hold out_ready=0 for 3 cycles:
  - in_ready=0 while all 4 stages are valid, and outputs are unchanged.
  - On out_ready=1, results drain in order with no loss.
  - A new input is accepted on the same edge.
- 3 operations in flight, then rst_n=0 for one edge:
  - All outputs are 0 and out_valid=0.
  - No stale result appears afterwards.
  - A fresh add after reset returns the correct value after 4 edges.
- With PIPE_ADD_SUB_EN:
  - sub=1, 0x0005-0x0003, Cin=0 -> Sum=0x0002, Cout=1.
  - 0x0003-0x0005 -> Sum=0xFFFE, Cout=0.
  - 0x8000-0x0001 -> Sum=0x7FFF, Ovf=1.
